ifu_ctl: RTL and testbench

IFU_CTL -- requirements
Module: ifu_ctl

---
 rtl/ifu_pkg.sv | 29 ++
 rtl/ifu_ctl.sv | 103 ++++++++++
 tb/tb_ifu_ctl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared encodings for the instruction-fetch controller: PC write source,
// PC increment amount and the controller state.
package ifu_pkg;

    typedef enum logic [1:0] {
        PC_WR_INC  = 2'b00,
        PC_WR_ALU  = 2'b01,
        PC_WR_TRAP = 2'b10
    } pc_wr_sel_t;

    typedef enum logic [1:0] {
        INC_4 = 2'b00,
        INC_2 = 2'b01,
        INC_0 = 2'b10
    } pc_inc_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DROP  = 2'b11
    } ifu_state_t;

    // Full-length instructions carry 2'b11 in their low bits; anything else is compressed.
    function automatic pc_inc_sel_t inc_for(input logic [1:0] low_bits);
        return (low_bits == 2'b11) ? INC_4 : INC_2;
    endfunction

endpackage

// File: rtl/ifu_ctl.sv
// Instruction-fetch controller: issues memory requests, holds one fetched
// instruction for decode, and steers PC updates including redirects.
module ifu_ctl
    import ifu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            run_i,
    input  logic            redirect_i,
    input  logic [1:0]      redirect_sel_i,
    input  logic [XLEN-1:0] pc_data_i,
    output logic            imem_req_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic            pc_wr_en_o,
    output logic [1:0]      pc_wr_sel_o,
    output logic [1:0]      pc_inc_sel_o,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_data_o,
    output logic [XLEN-1:0] inst_pc_o
);

    ifu_state_t  state;
    ifu_state_t  state_next;
    logic        capture;
    logic        wr_en;
    pc_wr_sel_t  wr_sel;
    pc_inc_sel_t inc_sel;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = PC_WR_INC;
        inc_sel    = INC_4;

        case (state)
            IDLE: begin
                if (!redirect_i && run_i) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // A redirect racing the ack lands the stale word here; the
                // request for the new PC is simply reissued from FETCH.
                if (redirect_i) begin
                    state_next = imem_ack_i ? FETCH : DROP;
                end else if (imem_ack_i) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                    wr_en      = 1'b1;
                    inc_sel    = inc_for(imem_data_i[1:0]);
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    state_next = FETCH;
                end else if (inst_ready_i) begin
                    state_next = run_i ? FETCH : IDLE;
                end
            end
            DROP: begin
                if (!redirect_i && imem_ack_i) begin
                    state_next = run_i ? FETCH : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect_i) begin
            wr_en   = 1'b1;
            wr_sel  = pc_wr_sel_t'(redirect_sel_i);
            inc_sel = INC_0;
        end
    end

    // Reset must silence the PC write path in the same cycle it is raised.
    assign pc_wr_en_o   = wr_en && !rst_i;
    assign pc_wr_sel_o  = rst_i ? '0 : wr_sel;
    assign pc_inc_sel_o = rst_i ? '0 : inc_sel;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            imem_req_o   <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_data_o  <= '0;
            inst_pc_o    <= '0;
        end else begin
            state        <= state_next;
            imem_req_o   <= (state_next == FETCH) || (state_next == DROP);
            inst_valid_o <= (state_next == HOLD);
            if (capture) begin
                inst_data_o <= imem_data_i;
                inst_pc_o   <= pc_data_i;
            end
        end
    end

endmodule

// File: tb/tb_ifu_ctl.sv
// Directed bench for ifu_ctl: a per-cycle reference model plus literal checks
// on the key transactions.
module tb_ifu_ctl;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            run = 1'b0;
    logic            redirect = 1'b0;
    logic [1:0]      redirect_sel = 2'b00;
    logic [XLEN-1:0] pc_data = '0;
    logic            imem_req;
    logic            imem_ack = 1'b0;
    logic [XLEN-1:0] imem_data = '0;
    logic            pc_wr_en;
    logic [1:0]      pc_wr_sel;
    logic [1:0]      pc_inc_sel;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_ctl #(.XLEN(XLEN)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .run_i          (run),
        .redirect_i     (redirect),
        .redirect_sel_i (redirect_sel),
        .pc_data_i      (pc_data),
        .imem_req_o     (imem_req),
        .imem_ack_i     (imem_ack),
        .imem_data_i    (imem_data),
        .pc_wr_en_o     (pc_wr_en),
        .pc_wr_sel_o    (pc_wr_sel),
        .pc_inc_sel_o   (pc_inc_sel),
        .inst_valid_o   (inst_valid),
        .inst_ready_i   (inst_ready),
        .inst_data_o    (inst_data),
        .inst_pc_o      (inst_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an outstanding request (possibly marked for discard) and an
    // optionally held instruction; idle means neither.
    logic            m_pending = 1'b0;
    logic            m_discard = 1'b0;
    logic            m_have    = 1'b0;
    logic [XLEN-1:0] m_data    = '0;
    logic [XLEN-1:0] m_pc      = '0;

    always @(negedge clk) begin
        logic       e_wr_en;
        logic [1:0] e_sel;
        logic [1:0] e_inc;
        logic       good_ack;
        good_ack = m_pending && !m_discard && imem_ack && !redirect;
        if (rst) begin
            e_wr_en = 1'b0; e_sel = 2'b00; e_inc = 2'b00;
        end else if (redirect) begin
            e_wr_en = 1'b1; e_sel = redirect_sel; e_inc = 2'b10;
        end else if (good_ack) begin
            e_wr_en = 1'b1; e_sel = 2'b00;
            e_inc   = (imem_data[1:0] == 2'b11) ? 2'b00 : 2'b01;
        end else begin
            e_wr_en = 1'b0; e_sel = 2'b00; e_inc = 2'b00;
        end
        chk("model.imem_req",   {31'd0, imem_req},   {31'd0, m_pending && !rst});
        chk("model.inst_valid", {31'd0, inst_valid}, {31'd0, m_have && !rst});
        chk("model.pc_wr_en",   {31'd0, pc_wr_en},   {31'd0, e_wr_en});
        chk("model.pc_wr_sel",  {30'd0, pc_wr_sel},  {30'd0, e_sel});
        chk("model.pc_inc_sel", {30'd0, pc_inc_sel}, {30'd0, e_inc});
        chk("model.inst_data",  inst_data, rst ? '0 : m_data);
        chk("model.inst_pc",    inst_pc,   rst ? '0 : m_pc);

        if (rst) begin
            m_pending = 1'b0; m_discard = 1'b0; m_have = 1'b0;
            m_data = '0; m_pc = '0;
        end else if (m_pending) begin
            if (redirect) begin
                m_discard = m_discard || !imem_ack;
            end else if (imem_ack) begin
                if (m_discard) begin
                    m_pending = run; m_discard = 1'b0;
                end else begin
                    m_pending = 1'b0; m_have = 1'b1;
                    m_data = imem_data; m_pc = pc_data;
                end
            end
        end else if (m_have) begin
            if (redirect) begin
                m_have = 1'b0; m_pending = 1'b1; m_discard = 1'b0;
            end else if (inst_ready) begin
                m_have = 1'b0; m_pending = run; m_discard = 1'b0;
            end
        end else if (run && !redirect) begin
            m_pending = 1'b1; m_discard = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) cyc();
        #1;
        chk("reset.imem_req",   {31'd0, imem_req},   32'd0);
        chk("reset.inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("reset.inst_data",  inst_data, 32'd0);
        rst = 1'b0; run = 1'b1; pc_data = 32'h100;

        // First fetch: ack on the second FETCH cycle with a 32-bit instruction.
        cyc(); #1;
        chk("fetch.req", {31'd0, imem_req}, 32'd1);
        cyc(); imem_ack = 1'b1; imem_data = 32'h0000_0013; #1;
        chk("ack.wr_en", {31'd0, pc_wr_en},  32'd1);
        chk("ack.sel",   {30'd0, pc_wr_sel}, 32'd0);
        chk("ack.inc4",  {30'd0, pc_inc_sel}, 32'd0);
        cyc(); imem_ack = 1'b0; imem_data = 32'hdead_beef; pc_data = 32'h104; #1;
        chk("hold.valid",  {31'd0, inst_valid}, 32'd1);
        chk("hold.data",   inst_data, 32'h13);
        chk("hold.pc",     inst_pc, 32'h100);
        chk("hold.no_req", {31'd0, imem_req}, 32'd0);
        chk("hold.single_pulse", {31'd0, pc_wr_en}, 32'd0);

        // Decode stalls for five cycles; a stray ack in HOLD must be ignored.
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i == 2);
            cyc(); #1;
            chk("stall.valid", {31'd0, inst_valid}, 32'd1);
            chk("stall.data",  inst_data, 32'h13);
            chk("stall.pc",    inst_pc, 32'h100);
        end
        imem_ack = 1'b0; inst_ready = 1'b1;
        cyc(); inst_ready = 1'b0; #1;
        chk("release.req",   {31'd0, imem_req},   32'd1);
        chk("release.valid", {31'd0, inst_valid}, 32'd0);

        // Compressed instruction.
        imem_ack = 1'b1; imem_data = 32'h0000_4501; #1;
        chk("rvc.inc2",  {30'd0, pc_inc_sel}, 32'd1);
        chk("rvc.wr_en", {31'd0, pc_wr_en}, 32'd1);
        cyc(); imem_ack = 1'b0; #1;
        chk("rvc.data", inst_data, 32'h4501);
        chk("rvc.pc",   inst_pc, 32'h104);
        inst_ready = 1'b1;
        cyc(); inst_ready = 1'b0;

        // Redirect before ack: DROP swallows the late response.
        redirect = 1'b1; redirect_sel = 2'b01; #1;
        chk("redir.wr_en", {31'd0, pc_wr_en},   32'd1);
        chk("redir.sel",   {30'd0, pc_wr_sel},  32'd1);
        chk("redir.inc0",  {30'd0, pc_inc_sel}, 32'd2);
        cyc(); redirect = 1'b0; #1;
        chk("drop.req", {31'd0, imem_req}, 32'd1);
        cyc(); imem_ack = 1'b1; imem_data = 32'h0000_0013; #1;
        chk("drop.ack_no_wr", {31'd0, pc_wr_en}, 32'd0);
        cyc(); imem_ack = 1'b0; #1;
        chk("drop.valid", {31'd0, inst_valid}, 32'd0);
        chk("drop.refetch", {31'd0, imem_req}, 32'd1);

        // Redirect coincident with ack: only the ALU write.
        redirect = 1'b1; redirect_sel = 2'b01; imem_ack = 1'b1; #1;
        chk("race.sel",  {30'd0, pc_wr_sel},  32'd1);
        chk("race.inc0", {30'd0, pc_inc_sel}, 32'd2);
        cyc(); redirect = 1'b0; imem_ack = 1'b0; #1;
        chk("race.valid", {31'd0, inst_valid}, 32'd0);
        chk("race.data_kept", inst_data, 32'h4501);

        // Trap redirect into DROP, second redirect with ack stays in DROP, then run low.
        redirect = 1'b1; redirect_sel = 2'b10;
        cyc(); imem_ack = 1'b1; #1;
        chk("drop_redir.sel", {30'd0, pc_wr_sel}, 32'd2);
        cyc(); redirect = 1'b0; imem_ack = 1'b0; run = 1'b0; #1;
        chk("drop_redir.req", {31'd0, imem_req}, 32'd1);
        cyc(); imem_ack = 1'b1;
        cyc(); imem_ack = 1'b0; #1;
        chk("drop_idle.req", {31'd0, imem_req}, 32'd0);

        // IDLE: redirect writes PC but blocks the start; ack ignored.
        redirect = 1'b1; redirect_sel = 2'b10; run = 1'b1;
        cyc(); redirect = 1'b0; #1;
        chk("idle_redir.req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1; #1;
        chk("idle_ack.wr_en", {31'd0, pc_wr_en}, 32'd0);
        cyc(); imem_ack = 1'b0;
        cyc(); run = 1'b0;
        cyc(); imem_ack = 1'b1; imem_data = 32'h0000_0033; pc_data = 32'h200; #1;
        chk("run_low.wr_en", {31'd0, pc_wr_en}, 32'd1);
        cyc(); imem_ack = 1'b0; #1;
        chk("run_low.pc", inst_pc, 32'h200);

        // Redirect in HOLD refetches even with run low.
        redirect = 1'b1; redirect_sel = 2'b01;
        cyc(); redirect = 1'b0; #1;
        chk("hold_redir.valid", {31'd0, inst_valid}, 32'd0);
        chk("hold_redir.req",   {31'd0, imem_req},   32'd1);
        imem_ack = 1'b1; imem_data = 32'h0000_0037; pc_data = 32'h300;
        cyc(); imem_ack = 1'b0;

        // Asynchronous reset while holding.
        #1 rst = 1'b1; redirect = 1'b1; #1;
        chk("arst.valid", {31'd0, inst_valid}, 32'd0);
        chk("arst.req",   {31'd0, imem_req},   32'd0);
        chk("arst.data",  inst_data, 32'd0);
        chk("arst.wr_en", {31'd0, pc_wr_en},   32'd0);
        cyc(); redirect = 1'b0; rst = 1'b0;
        cyc(); #1;
        chk("post_rst.req", {31'd0, imem_req}, 32'd0);
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
